// File: rtl/wb_axi_bridge_pkg.sv
// ============================================================================
// Module      : wb_axi_bridge_pkg
// Description : Shared definitions for the Wishbone-to-AXI bridge write path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_axi_bridge_pkg;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_EXOKAY  = 2'b01;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_DECERR  = 2'b11;
    // Reported in last_resp when a write is retired by the timeout
    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RESP = 2'd1,
        ST_COMPLETE  = 2'd2
    } trk_state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_id_fifo.sv
// ============================================================================
// Module      : axi_id_fifo
// Description : Synchronous FIFO of AXI IDs with head peek and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_id_fifo #(
    parameter int ID_WIDTH = 4,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [ID_WIDTH-1:0]        i_id,
    output logic [ID_WIDTH-1:0]        o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ID_WIDTH-1:0] r_mem_q [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr_q, w_wr_ptr_d;
    logic [PTR_W-1:0]    r_rd_ptr_q, w_rd_ptr_d;
    logic [CNT_W-1:0]    r_count_q,  w_count_d;
    logic                w_push;
    logic                w_pop;

    assign o_full  = (r_count_q == CNT_W'(DEPTH));
    assign o_empty = (r_count_q == '0);
    assign o_count = r_count_q;
    assign o_head  = r_mem_q[r_rd_ptr_q];

    // A full FIFO refuses a push even when a pop happens in the same cycle
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr_q] <= i_id;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_axi_bresp_tracker.sv
// ============================================================================
// Module      : wb_axi_bresp_tracker
// Description : In-order AXI B-response tracker producing Wishbone ack/err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_axi_bresp_tracker
    import wb_axi_bridge_pkg::*;
#(
    parameter int ID_WIDTH           = 4,
    parameter int MAX_OUTSTANDING    = 4,
    parameter int TIMEOUT_CYCLES     = 256,
    parameter int ENABLE_ERROR_CHECK = 1,
    parameter int ENABLE_ID_CHECK    = 1
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    input  logic                               req_valid,
    input  logic [ID_WIDTH-1:0]                req_id,
    output logic                               req_ready,
    input  logic [ID_WIDTH-1:0]                axi_bid,
    input  logic [1:0]                         axi_bresp,
    input  logic                               axi_bvalid,
    output logic                               axi_bready,
    output logic                               wb_ack,
    output logic                               wb_err,
    output logic [1:0]                         last_resp,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_cnt,
    output logic                               err_slv_sticky,
    output logic                               err_id_sticky,
    output logic                               err_to_sticky,
    input  logic                               clr_status
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [ID_WIDTH-1:0] w_head;
    logic                w_full;
    logic                w_empty;
    logic [CNT_W-1:0]    w_cnt;
    logic                w_push;
    logic                w_hs;
    logic                w_to_expire;
    logic                w_pop;
    logic                w_id_mis;
    logic                w_slv;

    trk_state_e          r_state_q,     w_state_d;
    logic                r_cpl_err_q,   w_cpl_err_d;
    logic [1:0]          r_last_resp_q, w_last_resp_d;
    logic [TO_W-1:0]     r_to_cnt_q,    w_to_cnt_d;
    logic                r_slv_q,       w_slv_d;
    logic                r_id_q,        w_id_d;
    logic                r_to_q,        w_to_d;

    axi_id_fifo #(
        .ID_WIDTH (ID_WIDTH),
        .DEPTH    (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (ACLK),
        .rst     (ARESET),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_id    (req_id),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_cnt)
    );

    assign w_push      = req_valid && !w_full;
    assign w_hs        = axi_bvalid && !w_empty;
    // A real response always beats an expiring timeout in the same cycle
    assign w_to_expire = TO_EN && !w_empty && !w_hs && (r_to_cnt_q == TO_LAST);
    assign w_pop       = w_hs || w_to_expire;
    assign w_id_mis    = (ENABLE_ID_CHECK != 0) && (axi_bid != w_head);
    assign w_slv       = (ENABLE_ERROR_CHECK != 0) && resp_is_err(axi_bresp) && !w_id_mis;

    always_comb begin
        w_to_cnt_d    = r_to_cnt_q;
        w_state_d     = ST_IDLE;
        w_cpl_err_d   = 1'b0;
        w_last_resp_d = r_last_resp_q;

        if (w_empty || w_pop || !TO_EN) begin
            w_to_cnt_d = '0;
        end else begin
            w_to_cnt_d = r_to_cnt_q + 1'b1;
        end

        if (w_pop) begin
            w_state_d = ST_COMPLETE;
        end else if (w_cnt != '0) begin
            w_state_d = ST_WAIT_RESP;
        end

        if (w_hs) begin
            w_cpl_err_d   = w_id_mis || w_slv;
            w_last_resp_d = axi_bresp;
        end else if (w_to_expire) begin
            w_cpl_err_d   = 1'b1;
            w_last_resp_d = RESP_TIMEOUT;
        end

        // Set events take precedence over a concurrent clear
        w_slv_d = (r_slv_q && !clr_status) || (w_hs && w_slv);
        w_id_d  = (r_id_q  && !clr_status) || (w_hs && w_id_mis);
        w_to_d  = (r_to_q  && !clr_status) || w_to_expire;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_q     <= ST_IDLE;
            r_cpl_err_q   <= 1'b0;
            r_last_resp_q <= RESP_OKAY;
            r_to_cnt_q    <= '0;
            r_slv_q       <= 1'b0;
            r_id_q        <= 1'b0;
            r_to_q        <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cpl_err_q   <= w_cpl_err_d;
            r_last_resp_q <= w_last_resp_d;
            r_to_cnt_q    <= w_to_cnt_d;
            r_slv_q       <= w_slv_d;
            r_id_q        <= w_id_d;
            r_to_q        <= w_to_d;
        end
    end

    assign wb_ack          = (r_state_q == ST_COMPLETE) && !r_cpl_err_q;
    assign wb_err          = (r_state_q == ST_COMPLETE) &&  r_cpl_err_q;
    assign last_resp       = r_last_resp_q;
    assign outstanding_cnt = w_cnt;
    assign req_ready       = !w_full;
    assign axi_bready      = !w_empty;
    assign err_slv_sticky  = r_slv_q;
    assign err_id_sticky   = r_id_q;
    assign err_to_sticky   = r_to_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_axi_bresp_tracker.sv
// ============================================================================
// Module      : tb_wb_axi_bresp_tracker
// Description : Directed self-checking bench for wb_axi_bresp_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_axi_bresp_tracker;

    localparam int IDW  = 4;
    localparam int MAXO = 4;
    localparam int TO   = 8;

    logic           ACLK = 1'b0;
    logic           ARESET;
    logic           req_valid;
    logic [IDW-1:0] req_id;
    logic           req_ready;
    logic [IDW-1:0] axi_bid;
    logic [1:0]     axi_bresp;
    logic           axi_bvalid;
    logic           axi_bready;
    logic           wb_ack;
    logic           wb_err;
    logic [1:0]     last_resp;
    logic [2:0]     outstanding_cnt;
    logic           err_slv_sticky;
    logic           err_id_sticky;
    logic           err_to_sticky;
    logic           clr_status;

    always #5 ACLK = ~ACLK;

    wb_axi_bresp_tracker #(
        .ID_WIDTH           (IDW),
        .MAX_OUTSTANDING    (MAXO),
        .TIMEOUT_CYCLES     (TO),
        .ENABLE_ERROR_CHECK (1),
        .ENABLE_ID_CHECK    (1)
    ) dut (
        .ACLK            (ACLK),
        .ARESET          (ARESET),
        .req_valid       (req_valid),
        .req_id          (req_id),
        .req_ready       (req_ready),
        .axi_bid         (axi_bid),
        .axi_bresp       (axi_bresp),
        .axi_bvalid      (axi_bvalid),
        .axi_bready      (axi_bready),
        .wb_ack          (wb_ack),
        .wb_err          (wb_err),
        .last_resp       (last_resp),
        .outstanding_cnt (outstanding_cnt),
        .err_slv_sticky  (err_slv_sticky),
        .err_id_sticky   (err_id_sticky),
        .err_to_sticky   (err_to_sticky),
        .clr_status      (clr_status)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of issued IDs plus how long the oldest has waited
    int m_q[$];
    int m_wait;
    bit m_ack, m_err, m_slv, m_id, m_to;
    int m_last;
    int m_n, m_head;
    bit m_hs, m_exp, m_set_s, m_set_i, m_set_t;

    always @(posedge ACLK) begin
        if (ARESET) begin
            m_q.delete();
            m_wait = 0; m_ack = 0; m_err = 0; m_last = 0;
            m_slv = 0; m_id = 0; m_to = 0;
        end else begin
            m_n = m_q.size();
            m_hs  = axi_bvalid && (m_n != 0);
            m_exp = !m_hs && (m_n != 0) && (m_wait == TO - 1);
            m_ack = 0; m_err = 0;
            m_set_s = 0; m_set_i = 0; m_set_t = 0;
            if (m_hs) begin
                m_head = m_q.pop_front();
                m_last = int'(axi_bresp);
                if (m_head != int'(axi_bid)) begin
                    m_err = 1; m_set_i = 1;
                end else if (axi_bresp >= 2) begin
                    m_err = 1; m_set_s = 1;
                end else begin
                    m_ack = 1;
                end
                m_wait = 0;
            end else if (m_exp) begin
                void'(m_q.pop_front());
                m_err = 1; m_set_t = 1; m_last = 3;
                m_wait = 0;
            end else if (m_n != 0) begin
                m_wait = m_wait + 1;
            end else begin
                m_wait = 0;
            end
            if (req_valid && (m_n < MAXO)) m_q.push_back(int'(req_id));
            m_slv = (m_slv && !clr_status) || m_set_s;
            m_id  = (m_id  && !clr_status) || m_set_i;
            m_to  = (m_to  && !clr_status) || m_set_t;
        end
    end

    always @(negedge ACLK) begin
        if (checking) begin
            chk("model ack",     wb_ack,          m_ack);
            chk("model err",     wb_err,          m_err);
            chk("model last",    last_resp,       m_last);
            chk("model cnt",     outstanding_cnt, m_q.size());
            chk("model ready",   req_ready,       m_q.size() < MAXO);
            chk("model bready",  axi_bready,      m_q.size() != 0);
            chk("model slv_st",  err_slv_sticky,  m_slv);
            chk("model id_st",   err_id_sticky,   m_id);
            chk("model to_st",   err_to_sticky,   m_to);
        end
    end

    // Every stimulus task starts and ends 2 time units after a rising edge
    task automatic push(input int id);
        req_valid = 1'b1;
        req_id    = IDW'(id);
        @(posedge ACLK); #2;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ACLK);
        #2;
    endtask

    task automatic bbeat(input int id, input int resp);
        axi_bvalid = 1'b1;
        axi_bid    = IDW'(id);
        axi_bresp  = 2'(resp);
        @(posedge ACLK); #2;
        axi_bvalid = 1'b0;
    endtask

    initial begin
        ARESET = 1'b1; req_valid = 1'b0; req_id = '0;
        axi_bid = '0; axi_bresp = 2'b00; axi_bvalid = 1'b0; clr_status = 1'b0;
        repeat (2) @(posedge ACLK);
        #2;
        ARESET   = 1'b0;
        checking = 1'b1;
        chk("reset ready",  req_ready, 1);
        chk("reset cnt",    outstanding_cnt, 0);
        chk("reset last",   last_resp, 0);
        chk("reset ack",    wb_ack, 0);
        chk("reset bready", axi_bready, 0);

        // Single write, response five cycles later
        push(3);
        chk("t1 cnt1", outstanding_cnt, 1);
        idle(4);
        bbeat(3, 0);
        chk("t1 ack", wb_ack, 1);
        chk("t1 err", wb_err, 0);
        chk("t1 cnt0", outstanding_cnt, 0);
        idle(1);
        chk("t1 ack gone", wb_ack, 0);

        // Fill, refuse a fifth push, drain back-to-back
        for (int i = 1; i <= 4; i++) push(i);
        chk("t2 full ready", req_ready, 0);
        push(5);
        chk("t2 refused cnt", outstanding_cnt, 4);
        axi_bvalid = 1'b1; axi_bresp = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            axi_bid = IDW'(i);
            @(posedge ACLK); #2;
            chk("t2 b2b ack", wb_ack, 1);
        end
        axi_bvalid = 1'b0;
        chk("t2 drained", outstanding_cnt, 0);
        bbeat(9, 0);
        chk("t2 empty b ignored", wb_ack, 0);

        // At full, push in the same cycle as a pop is still refused
        for (int i = 1; i <= 4; i++) push(i);
        req_valid = 1'b1; req_id = 4'd9;
        bbeat(1, 1);
        req_valid = 1'b0;
        chk("t2b exokay ack", wb_ack, 1);
        chk("t2b cnt3", outstanding_cnt, 3);
        for (int i = 2; i <= 4; i++) bbeat(i, 0);

        // Slave error then clear
        push(5);
        bbeat(5, 2);
        chk("t3 err", wb_err, 1);
        chk("t3 last", last_resp, 2);
        chk("t3 slv sticky", err_slv_sticky, 1);
        clr_status = 1'b1;
        idle(1);
        clr_status = 1'b0;
        chk("t3 cleared", err_slv_sticky, 0);

        // ID mismatch
        push(6);
        bbeat(7, 0);
        chk("t4 err", wb_err, 1);
        chk("t4 id sticky", err_id_sticky, 1);
        chk("t4 popped", outstanding_cnt, 0);

        // Timeout after TO cycles of silence
        push(2);
        idle(7);
        chk("t5 no err yet", wb_err, 0);
        idle(1);
        chk("t5 err", wb_err, 1);
        chk("t5 to sticky", err_to_sticky, 1);
        chk("t5 last", last_resp, 3);
        chk("t5 cnt", outstanding_cnt, 0);

        // Handshake coinciding with expiry wins
        push(4);
        idle(7);
        bbeat(4, 0);
        chk("t5b hs wins", wb_ack, 1);

        // Simultaneous push and pop when not full
        push(10);
        req_valid = 1'b1; req_id = 4'd11;
        bbeat(10, 0);
        req_valid = 1'b0;
        chk("t7 cnt same", outstanding_cnt, 1);
        bbeat(11, 0);

        // Reset with three pending entries
        push(1); push(2); push(3);
        ARESET = 1'b1;
        idle(1);
        ARESET = 1'b0;
        chk("t6 cnt", outstanding_cnt, 0);
        chk("t6 ready", req_ready, 1);
        chk("t6 ack", wb_ack, 0);
        chk("t6 err", wb_err, 0);
        idle(12);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
